// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1-style UART receiver with synchroniser, mid-bit sampling and valid/ack handshake
module uart_rx #(
    parameter int ClockFrequency = 1000000,
    parameter int BaudRate       = 9600,
    parameter int NrOfDataBits   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx,
    input  logic                    dataAck,
    output logic [NrOfDataBits-1:0] dataOut,
    output logic                    dataValid,
    output logic                    frameError,
    output logic                    overrunError,
    output logic                    busy
);

    localparam int BitTicks  = ClockFrequency / BaudRate;
    localparam int HalfTicks = BitTicks / 2;
    localparam int CntW      = $clog2(BitTicks) + 1;
    localparam int BitCntW   = (NrOfDataBits < 2) ? 1 : $clog2(NrOfDataBits + 1);

    localparam logic [CntW-1:0]    HalfLast = CntW'(HalfTicks - 1);
    localparam logic [CntW-1:0]    BitLast  = CntW'(BitTicks - 1);
    localparam logic [BitCntW-1:0] BitsLast = BitCntW'(NrOfDataBits - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync2_q;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [BitCntW-1:0]      bits_q, bits_d;
    logic [NrOfDataBits-1:0] shift_q, shift_d;
    logic [NrOfDataBits-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    ovr_q, ovr_d;
    logic                    byte_done;
    logic [NrOfDataBits:0]   shift_ext;

    // LSB arrives first, so each new sample enters at the top and moves down.
    assign shift_ext = {sync2_q, shift_q};

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        bits_d    = bits_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        byte_done = 1'b0;

        if (dataAck && valid_q) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bits_d  = '0;
                    state_d = sync2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = shift_ext[NrOfDataBits:1];
                    if (bits_q == BitsLast) begin
                        state_d = ST_STOP;
                    end else begin
                        bits_d = bits_q + BitCntW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        byte_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // A held-low line must return high before another start bit counts.
                cnt_d = '0;
                if (sync2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (byte_done) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !dataAck;
        end
    end

    assign dataOut      = data_q;
    assign dataValid    = valid_q;
    assign frameError   = ferr_q;
    assign overrunError = ovr_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - waveform-table bench for uart_rx with offline frame-decoding reference
module tb_uart_rx;

    localparam int BT   = 10;
    localparam int H    = 5;
    localparam int NB   = 8;
    localparam int MAXC = 8000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       dataAck = 1'b0;
    logic [7:0] dataOut;
    logic       dataValid, frameError, overrunError, busy;

    uart_rx #(
        .ClockFrequency(24_000_000),
        .BaudRate      (2_400_000),
        .NrOfDataBits  (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .dataAck     (dataAck),
        .dataOut     (dataOut),
        .dataValid   (dataValid),
        .frameError  (frameError),
        .overrunError(overrunError),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    bit       rx_w    [MAXC];
    bit       rst_w   [MAXC];
    bit       ack_w   [MAXC];
    bit       byte_at [MAXC];
    bit [7:0] byte_val[MAXC];
    bit       ferr_at [MAXC];
    bit       busy_e  [MAXC];
    bit       exp_v   [MAXC];
    bit [7:0] exp_d   [MAXC];
    bit       exp_fe  [MAXC];
    bit       exp_ov  [MAXC];

    int lit_cyc[$];
    int lit_sig[$];
    int lit_val[$];

    int wp;
    int ncyc;
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int cyc, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic put_line(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            rx_w[wp] = v;
            wp++;
        end
    endtask

    task automatic put_frame(input bit [7:0] b, input bit stop_ok);
        put_line(1'b0, BT);
        for (int i = 0; i < NB; i++) put_line(b[i], BT);
        put_line(stop_ok, BT);
    endtask

    task automatic lit(input int c, input int s, input int v);
        lit_cyc.push_back(c);
        lit_sig.push_back(s);
        lit_val.push_back(v);
    endtask

    // Line level the receiver decides on in cycle t: rx two cycles earlier, forced high after reset.
    function automatic bit rxs(input int t);
        if (t < 2 || t >= MAXC) return 1'b1;
        if (rst_w[t-1] || rst_w[t-2]) return 1'b1;
        return rx_w[t-2];
    endfunction

    function automatic int first_reset(input int a, input int b);
        for (int i = a; i <= b && i < MAXC; i++)
            if (rst_w[i]) return i;
        return -1;
    endfunction

    task automatic mark_busy(input int a, input int b);
        for (int i = a; i <= b && i < MAXC; i++) busy_e[i] = 1'b1;
    endtask

    // Walk the line history frame by frame using absolute sample times D+H+k*BT.
    task automatic analyse(input int n);
        int t, d, g, s, r, c;
        bit [7:0] b;
        t = 2;
        while (t < n) begin
            if (rst_w[t] || rxs(t)) begin
                t++;
                continue;
            end
            d = t;
            g = d + H;
            r = first_reset(d + 1, g);
            if (r >= 0) begin mark_busy(d + 1, r); t = r + 1; continue; end
            if (rxs(g)) begin mark_busy(d + 1, g); t = g + 1; continue; end
            s = g + (NB + 1) * BT;
            r = first_reset(g + 1, s);
            if (r >= 0) begin mark_busy(d + 1, r); t = r + 1; continue; end
            for (int i = 0; i < NB; i++) b[i] = rxs(g + (i + 1) * BT);
            if (rxs(s)) begin
                if (s < MAXC) begin byte_at[s] = 1'b1; byte_val[s] = b; end
                mark_busy(d + 1, s);
                t = s + 1;
            end else begin
                if (s < MAXC) ferr_at[s] = 1'b1;
                c = s + 1;
                while (c < n && !rst_w[c] && !rxs(c)) c++;
                mark_busy(d + 1, c);
                t = c + 1;
            end
        end
    endtask

    task automatic build_expect(input int n);
        bit v, fe, ov;
        bit [7:0] dv;
        v = 0; dv = 0; fe = 0; ov = 0;
        for (int t = 0; t < n - 1; t++) begin
            if (rst_w[t]) begin
                v = 0; dv = 0; fe = 0; ov = 0;
            end else begin
                fe = ferr_at[t];
                ov = byte_at[t] && v && !ack_w[t];
                if (byte_at[t]) begin
                    dv = byte_val[t];
                    v  = 1'b1;
                end else if (ack_w[t] && v) begin
                    v = 1'b0;
                end
            end
            exp_v[t+1]  = v;
            exp_d[t+1]  = dv;
            exp_fe[t+1] = fe;
            exp_ov[t+1] = ov;
        end
    endtask

    function automatic int model_sig(input int s, input int c);
        case (s)
            0: return int'(exp_v[c]);
            1: return int'(exp_d[c]);
            2: return int'(exp_fe[c]);
            3: return int'(exp_ov[c]);
            default: return int'(busy_e[c]);
        endcase
    endfunction

    function automatic int dut_sig(input int s);
        case (s)
            0: return int'(dataValid);
            1: return int'(dataOut);
            2: return int'(frameError);
            3: return int'(overrunError);
            default: return int'(busy);
        endcase
    endfunction

    initial begin
        int t1, t2, t3, t4, f4, t5, t6, r6, rs;
        int kind;
        for (int i = 0; i < MAXC; i++) rx_w[i] = 1'b1;
        for (int i = 0; i < 4; i++) rst_w[i] = 1'b1;
        wp = 20;

        t1 = wp;
        put_frame(8'hBA, 1'b1);
        put_line(1'b1, 20);
        ack_w[t1+110] = 1'b1;
        lit(t1 + 97, 0, 0); lit(t1 + 97, 4, 1);
        lit(t1 + 98, 0, 1); lit(t1 + 98, 1, 'hBA); lit(t1 + 98, 2, 0);
        lit(t1 + 98, 3, 0); lit(t1 + 98, 4, 0); lit(t1 + 111, 0, 0);

        t2 = wp;
        put_frame(8'h55, 1'b1);
        put_frame(8'hA3, 1'b1);
        put_line(1'b1, 20);
        ack_w[t2+210] = 1'b1;
        lit(t2 + 98, 1, 'h55); lit(t2 + 98, 3, 0);
        lit(t2 + 198, 1, 'hA3); lit(t2 + 198, 0, 1);
        lit(t2 + 198, 3, 1); lit(t2 + 199, 3, 0);

        t3 = wp;
        put_frame(8'h11, 1'b1);
        put_frame(8'hC7, 1'b1);
        put_line(1'b1, 30);
        ack_w[t3+197] = 1'b1;
        ack_w[t3+215] = 1'b1;
        lit(t3 + 198, 1, 'hC7); lit(t3 + 198, 0, 1);
        lit(t3 + 198, 3, 0); lit(t3 + 216, 0, 0);

        t4 = wp;
        put_line(1'b0, 3);
        put_line(1'b1, 20);
        f4 = wp;
        put_frame(8'h0F, 1'b1);
        put_line(1'b1, 30);
        lit(t4 + 7, 4, 1); lit(t4 + 8, 4, 0); lit(t4 + 10, 0, 0);
        lit(f4 + 98, 1, 'h0F); lit(f4 + 98, 0, 1);

        t5 = wp;
        put_frame(8'h81, 1'b0);
        put_line(1'b0, 50);
        put_line(1'b1, 30);
        lit(t5 + 97, 2, 0); lit(t5 + 98, 2, 1); lit(t5 + 99, 2, 0);
        lit(t5 + 98, 3, 0); lit(t5 + 99, 0, 1); lit(t5 + 99, 1, 'h0F);
        lit(t5 + 140, 4, 1); lit(t5 + 152, 4, 1); lit(t5 + 153, 4, 0);

        t6 = wp;
        put_frame(8'hF0, 1'b1);
        rst_w[t6+52] = 1'b1;
        put_line(1'b1, 20);
        r6 = wp;
        put_frame(8'h3C, 1'b1);
        put_line(1'b1, 20);
        lit(t6 + 52, 0, 1); lit(t6 + 52, 4, 1);
        lit(t6 + 53, 0, 0); lit(t6 + 53, 1, 0); lit(t6 + 53, 4, 0);
        lit(r6 + 98, 1, 'h3C); lit(r6 + 98, 0, 1);

        rs = wp;
        for (int k = 0; k < 30; k++) begin
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                put_line(1'b0, $urandom_range(1, 4));
                put_line(1'b1, $urandom_range(6, 12));
            end else if (kind == 1) begin
                put_frame(8'($urandom), 1'b0);
                put_line(1'b0, $urandom_range(0, 30));
                put_line(1'b1, $urandom_range(1, 10));
            end else begin
                put_frame(8'($urandom), 1'b1);
                put_line(1'b1, $urandom_range(0, 12));
            end
        end
        for (int c = rs; c < wp; c++) ack_w[c] = ($urandom_range(0, 15) == 0);
        rst_w[$urandom_range(rs + 200, wp - 1)] = 1'b1;
        put_line(1'b1, 40);
        ncyc = wp;

        analyse(ncyc);
        build_expect(ncyc);

        foreach (lit_cyc[i])
            check($sformatf("model_pin_sig%0d", lit_sig[i]), lit_cyc[i],
                  model_sig(lit_sig[i], lit_cyc[i]), lit_val[i]);

        for (int c = 0; c < ncyc; c++) begin
            @(posedge clock);
            #1;
            reset   = rst_w[c];
            rx      = rx_w[c];
            dataAck = ack_w[c];
            @(negedge clock);
            if (c >= 1) begin
                check("dataValid", c, int'(dataValid), int'(exp_v[c]));
                check("dataOut", c, int'(dataOut), int'(exp_d[c]));
                check("frameError", c, int'(frameError), int'(exp_fe[c]));
                check("overrunError", c, int'(overrunError), int'(exp_ov[c]));
                check("busy", c, int'(busy), int'(busy_e[c]));
                foreach (lit_cyc[i])
                    if (lit_cyc[i] == c)
                        check($sformatf("literal_sig%0d", lit_sig[i]), c, dut_sig(lit_sig[i]), lit_val[i]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
